// File: rtl/shift_out_pkg.sv
// ============================================================================
// Module : shift_out_pkg
// Brief  : State encoding and sizing helper for the serial result unloader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package shift_out_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_IDLE   = 2'b00;
    localparam state_t c_SHIFT  = 2'b01;
    localparam state_t c_PARITY = 2'b10;
    localparam state_t c_GAP    = 2'b11;

    // Bit counter must reach WIDTH without wrapping, plus one spare code.
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage : shift_out_pkg

`default_nettype wire

// File: rtl/shift_out_ser_rise_detect.sv
// ============================================================================
// Module : rise_detect
// Brief  : Registered rising-edge detector with selectable reset value.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rise_detect #(
    parameter bit RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_rise
);

    logic r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= RESET_VALUE;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_rise = i_d & ~r_q;

endmodule : rise_detect

`default_nettype wire

// File: rtl/shift_out_ser.sv
// ============================================================================
// Module : shift_out_ser
// Brief  : Captures a parallel product on a rising sz and shifts it out
//          serially with frame flag, busy/done status and an idle gap.
//          Define SHIFT_OUT_SER_PARITY_EN to append an even-parity bit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_out_ser
    import shift_out_pkg::*;
#(
    parameter int WIDTH     = 24,
    parameter bit LSB_FIRST = 1'b0,
    parameter int IDLE_GAP  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] z_parallel,
    input  logic             sz,
    output logic             z_out,
    output logic             fz,
    output logic             busy,
    output logic             done
);

    localparam int                 c_CNT_W       = cnt_width(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT    = c_CNT_W'(WIDTH - 1);
    localparam logic [7:0]         c_GAP_LAST    = 8'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);
    localparam state_t             c_AFTER_FRAME = (IDLE_GAP == 0) ? c_IDLE : c_GAP;

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_sreg;
    logic [c_CNT_W-1:0] r_cnt;
    logic [7:0]         r_gap;
    logic               r_done;
    logic               w_start;
    logic               w_last_fz;
    logic               w_data_bit;
`ifdef SHIFT_OUT_SER_PARITY_EN
    logic               r_parity;
`endif

    // Reset value 1 keeps an sz held high across reset release from starting a frame.
    rise_detect #(
        .RESET_VALUE (1'b1)
    ) u_start_detect (
        .clk    (clk),
        .reset  (reset),
        .i_d    (sz),
        .o_rise (w_start)
    );

    assign w_data_bit = LSB_FIRST ? r_sreg[0] : r_sreg[WIDTH-1];

`ifdef SHIFT_OUT_SER_PARITY_EN
    assign w_last_fz = (r_state == c_PARITY);
`else
    assign w_last_fz = (r_state == c_SHIFT) && (r_cnt == c_LAST_BIT);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_start) begin
                    w_next_state = c_SHIFT;
                end
            end
            c_SHIFT: begin
                if (r_cnt == c_LAST_BIT) begin
`ifdef SHIFT_OUT_SER_PARITY_EN
                    w_next_state = c_PARITY;
`else
                    w_next_state = c_AFTER_FRAME;
`endif
                end
            end
`ifdef SHIFT_OUT_SER_PARITY_EN
            c_PARITY: begin
                w_next_state = c_AFTER_FRAME;
            end
`endif
            c_GAP: begin
                if (r_gap == c_GAP_LAST) begin
                    w_next_state = c_IDLE;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sreg <= '0;
            r_cnt  <= '0;
            r_gap  <= '0;
            r_done <= 1'b0;
`ifdef SHIFT_OUT_SER_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_done <= w_last_fz;
            r_cnt  <= (r_state == c_SHIFT) ? r_cnt + 1'b1 : '0;
            r_gap  <= (r_state == c_GAP) ? r_gap + 8'd1 : 8'd0;
            if ((r_state == c_IDLE) && w_start) begin
                r_sreg <= z_parallel;
`ifdef SHIFT_OUT_SER_PARITY_EN
                r_parity <= ^z_parallel;
`endif
            end else if (r_state == c_SHIFT) begin
                r_sreg <= LSB_FIRST ? {1'b0, r_sreg[WIDTH-1:1]} : {r_sreg[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        fz    = 1'b0;
        z_out = 1'b0;
        busy  = (r_state != c_IDLE);
        done  = r_done;
        case (r_state)
            c_SHIFT: begin
                fz    = 1'b1;
                z_out = w_data_bit;
            end
`ifdef SHIFT_OUT_SER_PARITY_EN
            c_PARITY: begin
                fz    = 1'b1;
                z_out = r_parity;
            end
`endif
            default: begin
                fz    = 1'b0;
                z_out = 1'b0;
            end
        endcase
    end

endmodule : shift_out_ser

`default_nettype wire

// File: tb/tb_shift_out_ser.sv
// ============================================================================
// Module : tb_shift_out_ser
// Brief  : Scoreboard bench: dut0 WIDTH=24 MSB-first no gap, dut1 WIDTH=8
//          LSB-first IDLE_GAP=3; frames predicted at stimulus time.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_shift_out_ser;

`ifdef SHIFT_OUT_SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef struct {
        logic [31:0] word;
        int          first;
    } frame_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sz0 = 1'b1, sz1 = 1'b1;
    logic [23:0] zp0 = '0;
    logic [7:0]  zp1 = '0;
    logic        zo0, fz0, busy0, done0;
    logic        zo1, fz1, busy1, done1;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    frame_t q0[$];
    frame_t q1[$];
    bit          prev[2];
    int          free[2];
    int          last_first[2];
    bit          in_frame[2];
    bit          have_cur[2];
    int          pos[2];
    logic [31:0] cur_word[2];
    int          cur_first[2];

    logic        r, s0, s1;
    logic [23:0] z0;
    logic [7:0]  z1;

    shift_out_ser #(.WIDTH(24), .LSB_FIRST(1'b0), .IDLE_GAP(0)) dut0 (
        .clk(clk), .reset(reset), .z_parallel(zp0), .sz(sz0),
        .z_out(zo0), .fz(fz0), .busy(busy0), .done(done0)
    );

    shift_out_ser #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_GAP(3)) dut1 (
        .clk(clk), .reset(reset), .z_parallel(zp1), .sz(sz1),
        .z_out(zo1), .fz(fz1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int nb(input int d);
        return ((d == 0) ? 24 : 8) + PAR;
    endfunction

    function automatic int gapc(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic exp_bit(input int d, input logic [31:0] w, input int p);
        int          wd;
        logic [31:0] m;
        wd = (d == 0) ? 24 : 8;
        m  = (32'h1 << wd) - 32'h1;
        if (p >= wd) return ^(w & m);
        return (d == 1) ? w[p] : w[wd-1-p];
    endfunction

    task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL dut%0d %s cycle %0d: got %0h expected %0h", d, nm, cyc, act, exp);
        end
    endtask

    // Reference: a rising sz is accepted when the unit is free; the frame then
    // occupies nb cycles starting next cycle, followed by done and the gap.
    task automatic model(input int d, input logic rv, input logic sv, input logic [31:0] w);
        frame_t f;
        if (rv) begin
            prev[d] = 1'b1;
            free[d] = 0;
            if (d == 0) q0.delete(); else q1.delete();
            return;
        end
        if (sv && !prev[d] && cyc >= free[d]) begin
            f.word  = w;
            f.first = cyc + 1;
            if (d == 0) q0.push_back(f); else q1.push_back(f);
            last_first[d] = cyc + 1;
            free[d] = cyc + 1 + nb(d) + gapc(d);
        end
        prev[d] = sv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        reset = r; sz0 = s0; sz1 = s1; zp0 = z0; zp1 = z1;
        model(0, r, s0, {8'd0, z0});
        model(1, r, s1, {24'd0, z1});
    endtask

    task automatic run_until(input int x);
        int guard;
        guard = 0;
        while (cyc + 1 < x && guard < 1000) begin
            tick();
            guard++;
        end
    endtask

    task automatic mon(input int d, input logic fz, input logic zo, input logic bz, input logic dn);
        frame_t f;
        int     n;
        int     qs;
        logic   eb, ed;
        n = nb(d);
        if (reset) begin
            chk(d, "reset_outputs", {28'd0, fz, zo, bz, dn}, 32'd0);
            in_frame[d] = 1'b0;
            have_cur[d] = 1'b0;
            return;
        end
        if (fz === 1'b1 && !in_frame[d]) begin
            qs = (d == 0) ? q0.size() : q1.size();
            if (qs == 0) begin
                chk(d, "unexpected_frame", {31'd0, fz}, 32'd0);
                return;
            end
            if (d == 0) f = q0.pop_front(); else f = q1.pop_front();
            chk(d, "frame_start_cycle", cyc, f.first);
            cur_word[d]  = f.word;
            cur_first[d] = f.first;
            have_cur[d]  = 1'b1;
            in_frame[d]  = 1'b1;
            pos[d]       = 0;
        end
        if (in_frame[d]) begin
            chk(d, "frame_bit", {30'd0, fz, zo}, {30'd0, 1'b1, exp_bit(d, cur_word[d], pos[d])});
            pos[d]++;
            if (pos[d] == n || fz !== 1'b1) in_frame[d] = 1'b0;
        end else begin
            chk(d, "idle_outputs", {30'd0, fz, zo}, 32'd0);
        end
        eb = have_cur[d] && cyc >= cur_first[d] && cyc <= cur_first[d] + n - 1 + gapc(d);
        ed = have_cur[d] && cyc == cur_first[d] + n;
        chk(d, "busy_done", {30'd0, bz, dn}, {30'd0, eb, ed});
    endtask

    always @(negedge clk) begin
        mon(0, fz0, zo0, busy0, done0);
        mon(1, fz1, zo1, busy1, done1);
    end

    initial begin
        int c;
        r = 1'b1; s0 = 1'b1; s1 = 1'b1; z0 = 24'hA5C3F0; z1 = 8'h01;
        repeat (3) tick();
        // sz held high through reset release: no frame may appear
        r = 1'b0;
        repeat (6) tick();
        s0 = 1'b0; s1 = 1'b0; tick();
        s0 = 1'b1; s1 = 1'b1; tick();
        c = cyc;
        repeat (3) tick();
        s0 = 1'b0; s1 = 1'b0; z0 = 24'($urandom); z1 = 8'($urandom); tick();
        // rising sz at dut0 bit 10 and during dut1 gap: both ignored
        run_until(c + 10);
        s0 = 1'b1; s1 = 1'b1; tick();
        s1 = 1'b0; tick();
        s1 = 1'b1; tick();
        s1 = 1'b0;
        run_until(last_first[0] + nb(0) + 3);
        s0 = 1'b0; z0 = 24'($urandom); tick();
        s0 = 1'b1; tick();
        // back-to-back: rise exactly in the done cycle
        run_until(last_first[0] + nb(0) - 1);
        s0 = 1'b0; tick();
        s0 = 1'b1; z0 = 24'($urandom); tick();
        // reset at bit 12 of the new frame
        run_until(last_first[0] + 11);
        r = 1'b1; tick();
        #1;
        chk(0, "reset_immediate", {29'd0, fz0, zo0, busy0}, 32'd0);
        tick();
        r = 1'b0; s0 = 1'b0; tick();
        s0 = 1'b1; z0 = 24'($urandom); tick();
        run_until(last_first[0] + nb(0) + 5);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) s0 = ~s0;
            if ($urandom_range(0, 7) == 0) s1 = ~s1;
            z0 = 24'($urandom);
            z1 = 8'($urandom);
            r  = ($urandom_range(0, 399) == 0);
            tick();
        end

        r = 1'b0; s0 = 1'b0; s1 = 1'b0;
        repeat (60) tick();
        @(negedge clk);
        #1;
        chk(0, "frames_drained", q0.size() + int'(in_frame[0]), 32'd0);
        chk(1, "frames_drained", q1.size() + int'(in_frame[1]), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_shift_out_ser

`default_nettype wire
